// File: rtl/rx_ctrl.sv
// rtl/rx_ctrl.sv - triggered ADC capture framed as header+samples records, streamed out through an FWFT FIFO
module rx_ctrl #(
    parameter int          DW      = 32,
    parameter int          FIFO_AW = 10,
    parameter logic [15:0] HDR_TAG = 16'hA55A
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic [15:0]   rxsmps,
    input  logic [15:0]   rxdelay,
    input  logic [DW-1:0] adc_0,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic          busy,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          trig_miss
);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_CAP   = 2'd2;

    logic [1:0]         r_state;
    logic [15:0]        r_dly;
    logic [15:0]        r_left;
    logic [15:0]        r_seq;
    logic               r_ovf;
    logic               r_trig_miss;

    logic [DW:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic [DW-1:0]      r_out_data;
    logic               r_out_last;
    logic               r_out_valid;

    logic [31:0]        w_free;
    logic [31:0]        w_need;
    logic               w_start;
    logic               w_fits;
    logic               w_admit;
    logic               w_reject;
    logic               w_wr_en;
    logic [DW:0]        w_wr_word;
    logic               w_rd_en;

    // Free space counts only the memory, not the output register, so it errs on the safe side.
    assign w_free    = 32'(DEPTH) - 32'(r_count);
    assign w_need    = 32'(rxsmps) + 32'd1;
    assign w_start   = trig && (r_state == S_IDLE);
    assign w_fits    = (rxsmps != 16'd0) && (w_free >= w_need);
    assign w_admit   = w_start && w_fits;
    assign w_reject  = w_start && (rxsmps != 16'd0) && !w_fits;
    assign w_wr_en   = w_admit || (r_state == S_CAP);
    assign w_wr_word = w_admit ? {1'b0, DW'({HDR_TAG, r_seq})}
                               : {(r_left == 16'd1), adc_0};
    assign w_rd_en   = (r_count != '0) && (!r_out_valid || m_tready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dly       <= '0;
            r_left      <= '0;
            r_seq       <= '0;
            r_ovf       <= 1'b0;
            r_trig_miss <= 1'b0;
        end else begin
            r_trig_miss <= trig && (r_state != S_IDLE);
            if (w_reject)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (trig) begin
                        r_seq <= r_seq + 16'd1;
                        if (w_admit) begin
                            r_left  <= rxsmps;
                            r_dly   <= rxdelay;
                            r_state <= (rxdelay != 16'd0) ? S_DELAY : S_CAP;
                        end
                    end
                end
                S_DELAY: begin
                    r_dly <= r_dly - 16'd1;
                    if (r_dly == 16'd1)
                        r_state <= S_CAP;
                end
                S_CAP: begin
                    r_left <= r_left - 16'd1;
                    if (r_left == 16'd1)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= w_wr_word;
    end

    // Output register gives first-word-fall-through with one cycle of write-to-valid latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count <= r_count + {{FIFO_AW{1'b0}}, w_wr_en} - {{FIFO_AW{1'b0}}, w_rd_en};
            if (w_rd_en) begin
                r_rd_ptr                  <= r_rd_ptr + 1'b1;
                {r_out_last, r_out_data}  <= r_mem[r_rd_ptr];
                r_out_valid               <= 1'b1;
            end else if (m_tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign m_tdata   = r_out_data;
    assign m_tlast   = r_out_last;
    assign m_tvalid  = r_out_valid;
    assign busy      = (r_state != S_IDLE);
    assign overflow  = r_ovf;
    assign trig_miss = r_trig_miss;

endmodule
